// File: rtl/log_encode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : log_encode_pipe
//  Description : Two-stage pipelined Mitchell logarithm encoder feeding a
//                log-domain adder. Each unsigned operand X is encoded as
//                {k, frac}. k is the leading-one index of X. frac holds the
//                bits below that leading one, left-aligned and truncated to
//                FRAC bits. For a divide, log_b is bitwise inverted and cin
//                is set, so that the adder forms log(A) - log(B).
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready  : input handshake (in_ready is comb.)
//                in_a, in_b, in_op  : operands, 0 = multiply / 1 = divide
//                out_valid/out_ready: output handshake
//                log_a, log_b, cin, op_out, zero_a, zero_b : registered result
//  Revision    : 1.0  initial release
// ============================================================================
module log_encode_pipe #(
    parameter  int N    = 8,
    parameter  int FRAC = 5,
    localparam int LW   = $clog2(N) + FRAC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] log_a,
    output logic [LW-1:0] log_b,
    output logic          cin,
    output logic          op_out,
    output logic          zero_a,
    output logic          zero_b
);

    localparam int             c_KW   = $clog2(N);
    // Width of the alignment vector: every bit below the MSB plus FRAC pad bits.
    localparam int             c_EW   = N - 1 + FRAC;
    localparam logic [c_KW-1:0] c_KMAX = c_KW'(N - 1);

    // ------------------------------------------------------------------------
    // Encoder: returns {zero_flag, k, frac}.
    // The bits below the MSB are placed above FRAC zero bits. That vector is
    // shifted left so that the leading one drops off its top. The top FRAC
    // bits then hold the left-aligned mantissa. Zero padding for short
    // mantissas comes for free. A zero input gives k = 0 and frac = 0.
    // ------------------------------------------------------------------------
    function automatic logic [LW:0] f_encode(input logic [N-1:0] x);
        logic [c_KW-1:0] k;
        logic [c_EW-1:0] ext;
        logic [FRAC-1:0] frac;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                k = c_KW'(i);
            end
        end
        ext  = {x[N-2:0], {FRAC{1'b0}}} << (c_KMAX - k);
        frac = FRAC'(ext >> (N - 1));
        return {(x == '0), k, frac};
    endfunction

    // Stage 1 registers
    logic          r_s1_valid;
    logic [N-1:0]  r_s1_a;
    logic [N-1:0]  r_s1_b;
    logic          r_s1_op;

    // Stage 2 (output) registers
    logic          r_s2_valid;
    logic [LW-1:0] r_log_a;
    logic [LW-1:0] r_log_b;
    logic          r_cin;
    logic          r_op;
    logic          r_zero_a;
    logic          r_zero_b;

    logic          w_adv1;
    logic          w_adv2;
    logic [LW:0]   w_enc_a;
    logic [LW:0]   w_enc_b;

    // A stage may advance when it is empty or when the stage after it advances.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    always_comb begin
        w_enc_a = f_encode(r_s1_a);
        w_enc_b = f_encode(r_s1_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            // Payload only changes on a real accept, so that idle cycles leave it untouched.
            if (in_valid) begin
                r_s1_a  <= in_a;
                r_s1_b  <= in_b;
                r_s1_op <= in_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_log_a    <= '0;
            r_log_b    <= '0;
            r_cin      <= 1'b0;
            r_op       <= 1'b0;
            r_zero_a   <= 1'b0;
            r_zero_b   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_log_a  <= w_enc_a[LW-1:0];
                // Divide: the one's complement here, together with cin = 1,
                // makes the adder subtract log(B).
                r_log_b  <= r_s1_op ? ~w_enc_b[LW-1:0] : w_enc_b[LW-1:0];
                r_cin    <= r_s1_op;
                r_op     <= r_s1_op;
                r_zero_a <= w_enc_a[LW];
                r_zero_b <= w_enc_b[LW];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign log_a     = r_log_a;
    assign log_b     = r_log_b;
    assign cin       = r_cin;
    assign op_out    = r_op;
    assign zero_a    = r_zero_a;
    assign zero_b    = r_zero_b;

endmodule
`default_nettype wire

// File: tb/tb_log_encode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_log_encode_pipe
//  Description : Self-checking bench for log_encode_pipe. Directed vectors
//                plus scoreboarded streams are checked against an arithmetic
//                Mitchell-encoding model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_log_encode_pipe;

    localparam int N    = 8;
    localparam int FRAC = 5;
    localparam int LW   = 8;
    localparam int WW   = 2 * LW + 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          in_op;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] log_a;
    logic [LW-1:0] log_b;
    logic          cin;
    logic          op_out;
    logic          zero_a;
    logic          zero_b;

    int n_cmp  = 0;
    int n_fail = 0;

    log_encode_pipe #(.N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .log_a     (log_a),
        .log_b     (log_b),
        .cin       (cin),
        .op_out    (op_out),
        .zero_a    (zero_a),
        .zero_b    (zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word: {zero_b, zero_a, op_out, cin, log_b, log_a}
    wire [WW-1:0] w_obs = {zero_b, zero_a, op_out, cin, log_b, log_a};

    // Mitchell encoding from its arithmetic definition. k = floor(log2 x).
    // frac = floor((x - 2^k) * 2^FRAC / 2^k).
    function automatic int f_enc(input int x);
        int k;
        int frac;
        if (x == 0) return 0;
        k = 0;
        while ((2 << k) <= x) k++;
        frac = ((x - (1 << k)) << FRAC) >> k;
        return (k << FRAC) | frac;
    endfunction

    function automatic logic [WW-1:0] f_model(input int a, input int b, input bit op);
        logic [LW-1:0] la;
        logic [LW-1:0] lb;
        la = LW'(f_enc(a));
        lb = LW'(f_enc(b));
        if (op) lb = ~lb;
        return {(b == 0), (a == 0), op, op, lb, la};
    endfunction

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic op, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || w_obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b word=%h, required 0 / 0", out_valid, w_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 / 0", in_ready, out_valid);
        end
    endtask

    // One isolated pair through an empty pipeline, with exact latency checks.
    task automatic test_vector(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic op, input logic [WW-1:0] exp_word);
        drive(1'b1, a, b, op, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready=%b, required 1", name, in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early: out_valid=%b after one edge, required 0", name, out_valid);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || w_obs !== exp_word) begin
            n_fail++;
            $display("FAIL %s_data: out_valid=%b word=%h, required 1 / %h", name, out_valid, w_obs, exp_word);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_once: out_valid=%b after emit, required 0", name, out_valid);
        end
    endtask

    task automatic test_vectors;
        // {zb, za, op, cin, log_b, log_a}
        test_vector("mul_200_3", 8'd200, 8'd3,   1'b0, {4'b0000, 8'h30, 8'hF2});
        test_vector("div_200_3", 8'd200, 8'd3,   1'b1, {4'b0011, 8'hCF, 8'hF2});
        test_vector("mul_255_1", 8'd255, 8'd1,   1'b0, {4'b0000, 8'h00, 8'hFF});
        test_vector("zero_a",    8'd0,   8'd128, 1'b0, {4'b0100, 8'hE0, 8'h00});
        test_vector("model_rand", 8'd37, 8'd90,  1'b1, f_model(37, 90, 1'b1));
    endtask

    // mode 0: out_ready pattern 1,0,0,1 ; mode 1: random ; mode 2: continuous
    task automatic test_stream(input string name, input int mode, input int n_pairs);
        logic [WW-1:0] q[$];
        logic [WW-1:0] exp_w;
        logic [WW-1:0] prev_word;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic          op;
        logic          pending;
        logic          ordy;
        logic          prev_stall;
        logic          exp_rdy;
        int            sent;
        int            got;
        int            cyc;
        sent = 0; got = 0; cyc = 0;
        pending = 1'b0; prev_stall = 1'b0; prev_word = '0;
        a = '0; b = '0; op = 1'b0;
        while (got < n_pairs && cyc < 3000) begin
            if (!pending && sent < n_pairs) begin
                pending = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (pending) begin
                    case ($urandom_range(0, 7))
                        0:       a = '0;
                        1:       a = 8'd1;
                        2:       a = 8'd255;
                        default: a = N'($urandom);
                    endcase
                    b  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
                    op = 1'($urandom);
                end
            end
            case (mode)
                0:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
                1:       ordy = 1'($urandom);
                default: ordy = 1'b1;
            endcase
            drive(pending, a, b, op, ordy);

            exp_rdy = !(q.size() == 2 && !ordy);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s_in_ready: cyc=%0d got %b, required %b", name, cyc, in_ready, exp_rdy);
            end
            if (q.size() == 2 || q.size() == 0) begin
                n_cmp++;
                if (out_valid !== (q.size() == 2)) begin
                    n_fail++;
                    $display("FAIL %s_out_valid: cyc=%0d got %b, required %b", name, cyc, out_valid, q.size() == 2);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || w_obs !== prev_word) begin
                    n_fail++;
                    $display("FAIL %s_hold: cyc=%0d valid=%b word=%h, required 1 / %h", name, cyc, out_valid, w_obs, prev_word);
                end
            end
            if (out_valid === 1'b1 && ordy) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_spurious: cyc=%0d word=%h, required no output", name, cyc, w_obs);
                end else begin
                    exp_w = q.pop_front();
                    got++;
                    if (w_obs !== exp_w) begin
                        n_fail++;
                        $display("FAIL %s_data: item %0d got %h, required %h", name, got - 1, w_obs, exp_w);
                    end
                end
            end
            if (pending && in_ready === 1'b1) begin
                q.push_back(f_model(int'(a), int'(b), op));
                sent++;
                pending = 1'b0;
            end
            prev_stall = (out_valid === 1'b1) && !ordy;
            prev_word  = w_obs;
            cyc++;
        end
        n_cmp++;
        if (got != n_pairs || sent != n_pairs) begin
            n_fail++;
            $display("FAIL %s_count: sent=%0d emitted=%0d, required %0d each", name, sent, got, n_pairs);
        end
        if (mode == 2) begin
            // n pairs at one per cycle plus two-stage fill (the stop cycle is the last emit)
            n_cmp++;
            if (cyc != n_pairs + 2) begin
                n_fail++;
                $display("FAIL %s_rate: took %0d cycles, required %0d", name, cyc, n_pairs + 2);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 8'd77, 8'd5, 1'b0, 1'b0);
        drive(1'b1, 8'd99, 8'd6, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_full: out_valid=%b in_ready=%b, required 1 / 0", out_valid, in_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || w_obs !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: out_valid=%b word=%h, required 0 / 0", out_valid, w_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        test_vector("after_rst", 8'd16, 8'd4, 1'b1, {4'b0011, 8'hBF, 8'h80});
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stream("back_to_back", 0, 8);
        test_stream("random", 1, 150);
        test_reset_midflight();
        test_stream("throughput", 2, 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/log_encode_pipe.md
# log_encode_pipe

Two-stage pipelined Mitchell logarithm encoder that sits directly upstream of the SIMDive log-domain adder. It accepts two unsigned integer operands and an operation select (multiply/divide). It emits two fixed-point log values plus a carry-in, shaped so that the adder produces log(A)+log(B) for multiply or log(A)−log(B) for divide. Data moves under valid/ready handshakes on both sides, so the adder stage and the downstream antilog stage can stall it.

## Interface
- N, 8, operand width in bits; must be a power of two, ≥ 4
- FRAC, 5, fractional bits kept from the mantissa
- LW, $clog2(N)+FRAC (8 by default), log word width; derived, not overridden
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts the pair this cycle
- in_a  in  N  unsigned operand A (multiplicand/dividend)
- in_b  in  N  unsigned operand B (multiplier/divisor)
- in_op  in  1  0 = multiply, 1 = divide
- out_valid  out  1  output word valid
- out_ready  in  1  consumer (the adder stage) accepts this cycle
- log_a  out  LW  {k_A, frac_A}
- log_b  out  LW  {k_B, frac_B} when multiplying; bitwise ~{k_B, frac_B} when dividing
- cin  out  1  equals the op of the output word (1 for divide: completes two's-complement subtraction)
- op_out  out  1  op carried with the data
- zero_a, zero_b  out  1  operand was zero; log field is 0 (antilog stage forces the result)

## Operation
- Encoding of an operand X ≠ 0:
  - k is the index of the leading one, $clog2(N) bits.
  - frac is the bits strictly below the leading one, left-aligned, truncated to FRAC bits.
  - If fewer than FRAC bits exist, frac is zero-padded on the right.
  - No rounding.
- X = 0: zero flag = 1; k = 0 and frac = 0 before any divide inversion.
- X = 1: k = 0, frac = 0, zero flag = 0.
- Stage 1 (S1): registers in_a, in_b, in_op on accept.
- Stage 2 (S2):
  - Registers the encoded results, zero flags and op.
  - Applies the divide inversion to log_b.
  - Sets cin = op.
- Each stage has a valid bit.
  - S2 advance: adv2 = !s2_valid | out_ready.
  - S1 advance: adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational, no dependence on in_valid).
- S2 loads from S1 when adv2; s2_valid ← s1_valid.
- S1 loads when adv1; s1_valid ← in_valid & in_ready.
- Payload registers hold their value while their stage stalls.
- Data is never dropped or duplicated under arbitrary out_ready patterns.
- Simultaneous accept and emit in the same cycle is legal; full throughput is one pair per cycle.

## Timing
- Latency: a pair accepted at edge t is presented on the outputs after edge t+1; out_valid is high in the cycle following that edge (two register stages).
- Outputs are registered; in_ready is the only combinational output.
- Reset values:
  - s1_valid, s2_valid, out_valid = 0.
  - log_a, log_b, cin, op_out, zero_a, zero_b = 0.
  - in_ready = 1 while reset is deasserted and the pipeline is empty.
- Reset mid-operation: in-flight pairs are discarded asynchronously; the first accept after reset release behaves as from an empty pipeline.
- Full pipeline with out_ready = 0:
  - in_ready = 0.
  - All outputs stable until out_ready rises.
- Output-side rule: out_valid, once high, stays high with stable payload until out_ready = 1.

## Test plan
- Reset, then in_a=200, in_b=3, op=0, out_ready=1 → two cycles later: out_valid=1, log_a=0xF2, log_b=0x30, cin=0, zero flags 0.
- Same operands with op=1 → log_a=0xF2, log_b=0xCF, cin=1, op_out=1.
- Edge values:
  - in_a=255, in_b=1, op=0 → log_a=0xFF, log_b=0x00, zero_b=0.
  - in_a=0, in_b=128 → zero_a=1, log_a=0x00, log_b=0xE0.
- Back-to-back stream of 8 pairs with out_ready toggling 1,0,0,1,…:
  - Every pair appears exactly once, in order.
  - in_ready drops only when both stages are full.
  - Outputs hold steady during stalls.
- Assert rst while two pairs are in flight → out_valid=0 and all outputs 0 immediately; after release, a new pair (16, 4, op=1) yields log_a=0x80, log_b=~0x40=0xBF, cin=1.
- Continuous in_valid=1 with out_ready=1 → one output per cycle, in_ready constantly 1.
